// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial comparator sequencer.
// Build option: EARLY_EXIT_EN (decided-verdict early exit in SHIFT).
package serial_cmp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam int CLEAR_CYCLES  = 1;
  localparam int SETTLE_CYCLES = 1;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, MSB-first serial-out shift register.
// Load has priority over shift.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign sout = sr[WIDTH-1];

endmodule

// File: rtl/serial_compare_ctrl.sv
// Sequencer feeding two operands MSB-first into a bit-serial comparator.
// Build option: EARLY_EXIT_EN ends SHIFT as soon as G or L is decided.
module serial_compare_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             cmp_a,
  output logic             cmp_b,
  output logic             cmp_reset,
  input  logic             cmp_g,
  input  logic             cmp_e,
  input  logic             cmp_l,
  output logic             busy,
  output logic             done,
  output logic             res_g,
  output logic             res_e,
  output logic             res_l
);

  localparam int CW = cnt_width(WIDTH);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            sh_en;
  logic            a_bit;
  logic            b_bit;

  assign accept = start_valid && start_ready;
  // Shifting starts on the CLEAR exit edge so the MSB is already out.
  assign sh_en  = (state == S_CLEAR) || (state == S_SHIFT);

  piso_shift #(.WIDTH(WIDTH)) u_sh_a (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (sh_en),
    .din   (op_a),
    .sout  (a_bit)
  );

  piso_shift #(.WIDTH(WIDTH)) u_sh_b (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (sh_en),
    .din   (op_b),
    .sout  (b_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cmp_a       <= 1'b0;
      cmp_b       <= 1'b0;
      cmp_reset   <= 1'b1;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      res_g       <= 1'b0;
      res_e       <= 1'b0;
      res_l       <= 1'b0;
    end else begin
      done  <= 1'b0;
      cmp_a <= 1'b0;
      cmp_b <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_valid) begin
            state       <= S_CLEAR;
            cnt         <= CW'(WIDTH - 1);
            start_ready <= 1'b0;
            busy        <= 1'b1;
            cmp_reset   <= 1'b1;
          end
        end
        S_CLEAR: begin
          state     <= S_SHIFT;
          cmp_reset <= 1'b0;
          cmp_a     <= a_bit;
          cmp_b     <= b_bit;
        end
        S_SHIFT: begin
`ifdef EARLY_EXIT_EN
          if (cmp_g || cmp_l) begin
            state <= S_DONE;
            done  <= 1'b1;
            res_g <= cmp_g;
            res_e <= cmp_e;
            res_l <= cmp_l;
          end else if (cnt == '0) begin
            state <= S_SETTLE;
          end else begin
            cnt   <= cnt - 1'b1;
            cmp_a <= a_bit;
            cmp_b <= b_bit;
          end
`else
          if (cnt == '0) begin
            state <= S_SETTLE;
          end else begin
            cnt   <= cnt - 1'b1;
            cmp_a <= a_bit;
            cmp_b <= b_bit;
          end
`endif
        end
        S_SETTLE: begin
          state <= S_DONE;
          done  <= 1'b1;
          res_g <= cmp_g;
          res_e <= cmp_e;
          res_l <= cmp_l;
        end
        S_DONE: begin
          state       <= S_IDLE;
          start_ready <= 1'b1;
          busy        <= 1'b0;
          cmp_reset   <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl with an MSB-first comparator model.
// Define EARLY_EXIT_EN on both DUT and bench to check the early-exit build.
module tb_serial_compare_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_valid = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         start_ready, cmp_a, cmp_b, cmp_reset;
  logic         cmp_g = 1'b0, cmp_e = 1'b1, cmp_l = 1'b0;
  logic         busy, done, res_g, res_e, res_l;

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .cmp_reset   (cmp_reset),
    .cmp_g       (cmp_g),
    .cmp_e       (cmp_e),
    .cmp_l       (cmp_l),
    .busy        (busy),
    .done        (done),
    .res_g       (res_g),
    .res_e       (res_e),
    .res_l       (res_l)
  );

  always #5 clk = ~clk;

  // Behavioural comparator: registered, first differing bit decides.
  always @(posedge clk) begin
    if (cmp_reset) begin
      cmp_g <= 1'b0; cmp_e <= 1'b1; cmp_l <= 1'b0;
    end else if (cmp_e) begin
      if (cmp_a && !cmp_b) begin
        cmp_g <= 1'b1; cmp_e <= 1'b0;
      end else if (!cmp_a && cmp_b) begin
        cmp_l <= 1'b1; cmp_e <= 1'b0;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]   res;
    int           lat;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t exp_q[$];

  function automatic int exp_lat(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
`ifdef EARLY_EXIT_EN
    for (int j = 0; j <= W - 2; j++)
      if (a[W-1-j] != b[W-1-j]) return 4 + j;
`endif
    return W + 3;
  endfunction

  function automatic logic [2:0] exp_res(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  bit           active = 0;
  bit           acc_m;
  int           since = 0;
  int           cyc = 0;
  int           last_acc = 0;
  int           acc_gap = 0;
  int           acc_cnt = 0;
  logic [W-1:0] sa_s, sb_s;

  always @(posedge clk) begin
    exp_t e;
    acc_m = reset && start_valid && start_ready;
    #1;
    cyc++;
    if (reset) begin
      if (active) begin
        since++;
        if (since >= 1 && since <= W) begin
          sa_s = {sa_s[W-2:0], cmp_a};
          sb_s = {sb_s[W-2:0], cmp_b};
        end
      end
      if (acc_m) begin
        e.a = op_a; e.b = op_b;
        e.res = exp_res(op_a, op_b);
        e.lat = exp_lat(op_a, op_b);
        exp_q.push_back(e);
        active = 1; since = 0;
        acc_gap = cyc - last_acc; last_acc = cyc;
        acc_cnt++;
        check("clear_cycle", {cmp_reset, cmp_a, cmp_b}, 3'b100);
      end
      check("busy", busy, active);
      check("ready", start_ready, !active);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_spurious", done, 0);
        end else begin
          e = exp_q.pop_front();
          check("res", {res_g, res_e, res_l}, e.res);
          check("latency", since + 1, e.lat);
          if (e.lat == W + 3) begin
            check("stream_a", sa_s, e.a);
            check("stream_b", sb_s, e.b);
          end
        end
        active = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit keep);
    bit ok = 0;
    @(negedge clk);
    op_a = a; op_b = b; start_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      ok = reset && start_ready;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(negedge clk);
    if (!keep) start_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b, 0);
    wait_done();
  endtask

  initial begin
    int n0;
    bit hit;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", start_ready, 1);
      check("rst_busy_done", {busy, done}, 2'b00);
      check("rst_res", {res_g, res_e, res_l}, 3'b000);
      check("rst_cmp", {cmp_reset, cmp_a, cmp_b}, 3'b100);
    end
    reset = 1'b1;
    @(negedge clk);

    run(8'hA5, 8'hA5);
    run(8'h80, 8'h7F);
    issue(8'h01, 8'h02, 0);
    check("b2b_gap", acc_gap, W + 4);
    wait_done();
    run(8'h00, 8'h01);
    run(8'hFF, 8'h00);

    // Operands churn while busy; only the first set may be compared.
    n0 = acc_cnt;
    issue(8'h33, 8'h30, 1);
    repeat (6) begin
      @(negedge clk);
      op_a = W'($urandom); op_b = W'($urandom);
    end
    wait_done();
    check("no_reaccept", acc_cnt - n0, 1);
    op_a = 8'h44; op_b = 8'h44;
    @(negedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    check("next_accept", acc_cnt - n0, 2);
    wait_done();

    // Abort in the SHIFT cycle presenting bit 4.
    issue(8'h5A, 8'h5B, 0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (active && since == 4) hit = 1;
      else @(negedge clk);
    end
    if (!hit) check("shift_timeout", 0, 1);
    reset = 1'b0;
    exp_q.delete();
    active = 0;
    #1;
    check("abort_res", {res_g, res_e, res_l}, 3'b000);
    check("abort_state", {start_ready, busy, done, cmp_reset}, 4'b1001);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_res_hold", {res_g, res_e, res_l}, 3'b000);

    run(8'h12, 8'h34);
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_compare_ctrl.md
# serial_compare_ctrl

Sequencer for the bit-serial magnitude comparator (inputs a, b; registered outputs G, E, L; active-high reset). Accepts two WIDTH-bit operands over a valid/ready handshake and clears the comparator. It then shifts the operands into the comparator MSB-first, samples the G/E/L verdict and returns it with a one-cycle done pulse. It sits between any parallel-word client and one comparator instance.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low
- start_valid  input  1  request to compare op_a/op_b
- start_ready  output  1  high only in IDLE
- op_a  input  WIDTH  operand A, sampled on accept
- op_b  input  WIDTH  operand B, sampled on accept
- cmp_a  output  1  serial bit to comparator input a
- cmp_b  output  1  serial bit to comparator input b
- cmp_reset  output  1  active-high clear to comparator
- cmp_g, cmp_e, cmp_l  input  1 each  comparator verdict (registered, one-cycle lag)
- busy  output  1  high from accept until done
- done  output  1  one-cycle pulse, result valid
- res_g, res_e, res_l  output  1 each  captured verdict, held until next done

## Operation
- States: IDLE, CLEAR, SHIFT, SETTLE, DONE.
- IDLE: start_ready=1. Accept is start_valid && start_ready at a clock edge. On accept, op_a/op_b are loaded into shift registers, the bit counter is set to WIDTH-1, and the FSM goes to CLEAR. start_valid is ignored in all other states, and operands are not re-sampled.
- CLEAR: one cycle with cmp_reset=1 and cmp_a=cmp_b=0, then SHIFT.
- SHIFT: WIDTH cycles. Cycle k presents bit WIDTH-1-k of each operand on cmp_a/cmp_b. Shift registers shift left and the counter decrements. When the counter reaches 0, go to SETTLE.
- SETTLE: one cycle with cmp_a=cmp_b=0, covering the comparator's output lag. At the end of this cycle cmp_g/e/l are captured into res_g/e/l, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- The captured verdict is raw. Non-one-hot G/E/L from the comparator is passed through unchanged.
- busy equals (state != IDLE).
- Asynchronous reset (reset=0) in any state forces IDLE immediately and clears shift registers, counter and results.

## Timing
- Reset values: start_ready=1, busy=0, done=0, res_g=res_e=res_l=0, cmp_a=cmp_b=0, cmp_reset=1. The comparator is held cleared while reset is low.
- Latency: done asserts WIDTH+3 cycles after the accepting edge. For WIDTH=8, that is 11 cycles.
- Throughput: one comparison per WIDTH+4 cycles. start_ready returns high in the cycle after done.
- Results change only on the edge that enters DONE.
- Reset mid-SHIFT: the partial comparison is discarded, no done is issued, and res_* read 0.

## Configuration
- EARLY_EXIT_EN defined:
  - In SHIFT, cmp_g or cmp_l high means the MSB-first difference is already decided.
  - Capture cmp_g/e/l immediately and go to DONE, skipping the remaining bits and SETTLE.
  - Latency becomes data-dependent. It ranges from 4 cycles (MSBs differ) to WIDTH+3.
- EARLY_EXIT_EN undefined: always the full WIDTH shift plus SETTLE, so latency is fixed at WIDTH+3.

## Structure
- Package serial_cmp_pkg holds:
  - the state enum typedef
  - CLEAR_CYCLES=1 and SETTLE_CYCLES=1
  - a function giving the counter width, $clog2(WIDTH)
- Sub-module piso_shift: a parallel-load, MSB-first serial-out shift register with load and shift enables. It is instantiated twice, once per operand.
- The FSM, counter and result registers stay in serial_compare_ctrl.

## Test plan
All scenarios use WIDTH=8 with a behavioural MSB-first comparator model.
- Reset: hold reset=0 for 3 cycles, then release -> start_ready=1, busy=0, done=0, res=000, cmp_reset=1 during reset.
- Equal operands: op_a=0xA5, op_b=0xA5 -> done 11 cycles after accept, res_e=1, res_g=0, res_l=0. cmp_a/cmp_b serial stream is 1,0,1,0,0,1,0,1.
- Greater and less:
  - op_a=0x80, op_b=0x7F -> res_g=1.
  - Back-to-back with op_a=0x01, op_b=0x02 -> res_l=1.
  - With EARLY_EXIT_EN, the first comparison's done arrives 4 cycles after accept.
- Busy: start_valid held high with changing operands during SHIFT -> no second accept, result matches the first operands, next accept only after done.
- Reset mid-SHIFT at bit 4 -> immediate IDLE, no done pulse, res=000. A new request then completes normally.
- LSB-only difference: op_a=0x00, op_b=0x01 -> res_l=1 after the full 11 cycles, both with and without EARLY_EXIT_EN.
